// File: rtl/axi_adc_jesd204_cpack.sv
// Packs the samples of the enabled ADC channels into full-width words with no gaps.
// Stage 1 compacts the enabled channels of each beat. Stage 2 fills a word one beat at a time.
module axi_adc_jesd204_cpack #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 2
) (
    input  logic                                          adc_clk,
    input  logic                                          adc_rst,
    input  logic                                          adc_valid,
    input  logic [NUM_CHANNELS-1:0]                       adc_enable,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0]    adc_data,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0]    adc_packed_data,
    output logic                                          adc_packed_valid,
    output logic                                          adc_packed_err
);

    localparam int NS = NUM_CHANNELS * DATA_PATH_WIDTH;
    localparam int W  = NS * 16;
    localparam int CW = $clog2(NUM_CHANNELS) + 1;

    logic [W-1:0]            compact;
    int                      e_in;
    int                      rank;
    logic                    in_legal;

    logic                    s1_valid;
    logic [W-1:0]            s1_data;
    logic [CW-1:0]           s1_count;
    logic                    s1_illegal;
    logic                    s1_change;
    logic [NUM_CHANNELS-1:0] prev_enable;

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_eff;
    logic [W-1:0]            accum;
    logic [W-1:0]            word_next;
    logic                    last_beat;
    int                      e_s1;
    int                      base;

    // Rank k of an enabled channel is the number of enabled channels below it.
    always_comb begin
        compact = '0;
        e_in    = 0;
        rank    = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            e_in = e_in + int'(adc_enable[c]);
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (adc_enable[c]) begin
                for (int d = 0; d < DATA_PATH_WIDTH; d++) begin
                    compact[(d*e_in + rank)*16 +: 16] = adc_data[(c*DATA_PATH_WIDTH + d)*16 +: 16];
                end
                rank = rank + 1;
            end
        end
        in_legal = (e_in != 0) && ((e_in & (e_in - 1)) == 0);
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_count    <= '0;
            s1_illegal  <= 1'b0;
            s1_change   <= 1'b0;
            prev_enable <= '0;
        end else begin
            s1_valid <= adc_valid;
            if (adc_valid) begin
                s1_data     <= compact;
                s1_count    <= CW'(e_in);
                s1_illegal  <= !in_legal;
                s1_change   <= (adc_enable != prev_enable);
                prev_enable <= adc_enable;
            end
        end
    end

    // A mask change restarts the word at this beat, even if the old word was one beat short.
    always_comb begin
        e_s1      = int'(s1_count);
        cnt_eff   = s1_change ? '0 : cnt;
        base      = int'(cnt_eff) * e_s1 * DATA_PATH_WIDTH;
        word_next = accum;
        for (int i = 0; i < NS; i++) begin
            if ((i < e_s1 * DATA_PATH_WIDTH) && (base + i < NS)) begin
                word_next[(base + i)*16 +: 16] = s1_data[i*16 +: 16];
            end
        end
        last_beat = ((int'(cnt_eff) + 1) * e_s1) == NUM_CHANNELS;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            cnt              <= '0;
            accum            <= '0;
            adc_packed_data  <= '0;
            adc_packed_valid <= 1'b0;
            adc_packed_err   <= 1'b0;
        end else begin
            adc_packed_valid <= 1'b0;
            adc_packed_err   <= s1_illegal;
            if (s1_valid && !s1_illegal) begin
                if (last_beat) begin
                    adc_packed_data  <= word_next;
                    adc_packed_valid <= 1'b1;
                    cnt              <= '0;
                end else begin
                    accum <= word_next;
                    cnt   <= cnt_eff + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/axi_adc_jesd204_cpack.md
# axi_adc_jesd204_cpack

Channel packer placed directly downstream of the per-channel ADC format stage in the JESD204 ADC core. It takes the formatted 16-bit samples of all channels plus their per-channel enables. It interleaves the samples of the enabled channels only, in sample order, and emits full-width words to the DMA/FIFO interface. Output words are packed without gaps, so the sink sees a contiguous sample stream whatever the enable mask.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of channels; power of two, 1..8
- DATA_PATH_WIDTH, 2, samples per channel per beat; power of two, 1..4

Ports (W = NUM_CHANNELS*DATA_PATH_WIDTH*16):
- adc_clk  in  1  single clock; all logic on rising edge
- adc_rst  in  1  reset, synchronous, active-high
- adc_valid  in  1  input beat qualifier
- adc_enable  in  NUM_CHANNELS  per-channel enable, sampled with each beat
- adc_data  in  W  channel c sample d at bits [(c*DATA_PATH_WIDTH+d)*16 +: 16]
- adc_packed_data  out  W  packed word; slot 0 in LSBs
- adc_packed_valid  out  1  one-cycle strobe per completed word
- adc_packed_err  out  1  high while the registered enable count is illegal

## Operation
- E = popcount(adc_enable). E is legal if it is a power of two in 1..NUM_CHANNELS. Beats per word: B = NUM_CHANNELS/E.
- Compaction (stage 1, registered):
  - Let k be the rank of an enabled channel, ascending by channel index.
  - Sample d of rank k goes to compact position d*E+k.
  - A compacted beat therefore holds E*DATA_PATH_WIDTH samples.
- Accumulation (stage 2):
  - A beat counter cnt runs 0..B-1.
  - Beat j is written to word slots j*E*DATA_PATH_WIDTH upward.
  - When cnt==B-1, the full word is loaded into adc_packed_data, adc_packed_valid pulses, and cnt returns to 0.
- Beats with adc_valid=0 are ignored: no slot is written and cnt does not advance.
- Enable change:
  - The enable vector of each valid beat is compared with that of the previous valid beat.
  - On a mismatch, the partial word is discarded and the differing beat becomes slot 0 of a new word (cnt restarts at it).
- Illegal E (0, or not a power of two):
  - Beats are dropped and no valid is produced.
  - adc_packed_err=1 from the stage-1 register onward.
  - Returning to a legal mask counts as an enable change, so packing restarts at slot 0.
- Unused (disabled) channel data never reaches the output.
- adc_packed_data holds its last value between valid strobes.

## Timing
- Reset values: adc_packed_data=0, adc_packed_valid=0, adc_packed_err=0, cnt=0, stage-1 valid=0, stored enable vector=0.
- Reset takes effect on the first rising edge with adc_rst=1. All partial and in-flight data is discarded; the first valid beat after reset release is slot 0.
- Latency: the last beat of a word, presented in cycle n, gives adc_packed_valid=1 in cycle n+2.
- adc_packed_err follows an enable change with the same 2-cycle latency.
- Throughput: 1 beat/cycle, no backpressure. adc_packed_valid is high at most 1 cycle in B; every cycle when E=NUM_CHANNELS.
- Simultaneous enable change and word-completing beat: the change wins. The old partial word is dropped, and the beat counts as slot 0 of the new mask (it completes a word only if B=1).
- cnt width is clog2(NUM_CHANNELS)+1. The counter never exceeds B-1.

## Test plan
- Full mask: NUM_CHANNELS=4, DPW=2, enable=4'b1111, 10 consecutive beats -> 10 valid words, latency 2. Each word equals the interleaved order ch0s0,ch1s0,ch2s0,ch3s0,ch0s1,… (LSB first).
- Partial mask: enable=4'b1010, ch1 samples A0..A3 and ch3 samples B0..B3 over 2 beats -> one word A0,B0,A1,B1,A2,B2,A3,B3, with valid only after the 2nd beat.
- Single channel with valid gaps: enable=4'b0100, 4 valid beats separated by adc_valid=0 cycles -> one word of ch2 samples s0..s7 in order, valid 2 cycles after the 4th valid beat.
- Illegal mask: enable=4'b0111 for 6 beats -> adc_packed_err=1 from cycle 2, no valid. Then switch to 4'b0011 -> err clears, words resume starting at slot 0.
- Enable change mid-word: enable=4'b0001, 2 beats, then 4'b0011, 2 beats -> first partial word dropped. Exactly one word is produced, containing only the 4'b0011 beats.
- Reset mid-word: 4'b0001, 3 beats, adc_rst for 1 cycle, then 4 beats -> outputs 0 after reset. One word containing only the post-reset beats.
